// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing, single-outstanding imem requests,
// valid/ready presentation to the decoder, branch redirect with response squash.
// Optional feature macro: IF_PERF_CNT_EN (adds perf_fetch_cnt / perf_flush_cnt).
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  pc_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, FLUSH} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;

  // Decoder sees the opcode field of whatever instruction is held.
  assign opcode = instr[INSTR_W-1 -: 4];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and request decode; a redirect overrides the normal transitions.
  always_comb begin
    state_nx       = state;
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        imem_req_valid = 1'b1;
        imem_addr      = pc;
        if (imem_req_ready) state_nx = WAIT;
      end
      WAIT:  if (imem_resp_valid) state_nx = ISSUE;
      ISSUE: if (instr_valid && instr_ready) state_nx = FETCH;
      FLUSH: if (imem_resp_valid) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
    if (branch_taken) begin
      case (state)
        FETCH:   state_nx = imem_req_ready  ? FLUSH : FETCH;  // old-PC request already accepted
        WAIT:    state_nx = imem_resp_valid ? FETCH : FLUSH;  // response consumed now or later
        FLUSH:   state_nx = imem_resp_valid ? FETCH : FLUSH;
        default: state_nx = FETCH;                            // IDLE/ISSUE: held instr dropped
      endcase
    end
  end

  // PC and presented-instruction registers; redirect wins over capture/handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= ADDR_W'(RESET_PC);
      instr       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= branch_target;
      instr_valid <= 1'b0;
    end else if (state == WAIT && imem_resp_valid) begin
      instr       <= imem_resp_data;
      pc_out      <= pc;
      pc          <= pc + ADDR_W'(1);
      instr_valid <= 1'b1;
    end else if (state == ISSUE && instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic hs, drop;
  assign hs   = (state == ISSUE) && instr_valid && instr_ready && !branch_taken;
  assign drop = imem_resp_valid && ((state == FLUSH) || (state == WAIT && branch_taken));

  // Saturating counters for delivered and squashed instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hs && perf_fetch_cnt != 16'hFFFF)   perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (drop && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run scored against a sequential-PC reference model with a one-slot memory model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [15:0] imem_resp_data = '0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  pc_out;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .pc_out(pc_out)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cmp_n = 0, err_n = 0;

  // memory image and one-slot response model
  logic [15:0] mem [256];
  int          mem_k = 1;
  bit          pend = 0, psq = 0;
  int          pcnt = 0;
  logic [15:0] pdata = '0;
  bit          acc = 0;
  logic [7:0]  acc_addr = '0;
  int          n_hs = 0, n_drop = 0, overlap = 0;

  // One clock cycle: drive inputs at the falling edge, model memory, observe handshakes.
  task automatic cyc(input bit r, input bit rdy, input bit irdy, input bit br, input logic [7:0] tgt);
    @(negedge clk);
    rst = r; imem_req_ready = rdy; instr_ready = irdy;
    branch_taken = br; branch_target = tgt;
    acc = 0;
    if (r) begin n_hs = 0; n_drop = 0; end
    if (pend) psq = psq | br;
    if (pend && pcnt == 1) begin
      imem_resp_valid = 1'b1; imem_resp_data = pdata; pend = 0;
      if (psq && !r) n_drop++;
    end else begin
      imem_resp_valid = 1'b0;
      if (pend) pcnt--;
    end
    if (imem_req_valid && rdy && !r) begin
      if (pend) overlap++;
      pend = 1; psq = br; pcnt = mem_k; pdata = mem[imem_addr];
      acc = 1; acc_addr = imem_addr;
    end
    if (!r && instr_valid && irdy && !br) n_hs++;
  endtask

  task automatic test_reset();
    repeat (3) cyc(1, 0, 0, 0, 8'h00);
    cmp_n++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || instr !== 16'h0 ||
        pc_out !== 8'h0 || opcode !== 4'h0) begin
      err_n++;
      $display("FAIL reset_vals: valid=%b req=%b instr=%h pc_out=%h op=%h, want 0 0 0000 00 0",
               instr_valid, imem_req_valid, instr, pc_out, opcode);
    end
`ifdef IF_PERF_CNT_EN
    cmp_n++;
    if (perf_fetch_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin
      err_n++;
      $display("FAIL reset_perf: fetch=%0d flush=%0d want 0 0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    logic [15:0] ex_i [3];
    logic [3:0]  ex_o [3];
    logic [7:0]  addrs [3];
    int first_v, nh, na, last_c;
    ex_i[0] = 16'h1000; ex_i[1] = 16'h2345; ex_i[2] = 16'h3ABC;
    ex_o[0] = 4'h1;     ex_o[1] = 4'h2;     ex_o[2] = 4'h3;
    first_v = 0; nh = 0; na = 0; last_c = 0;
    mem_k = 1;
    cyc(0, 1, 1, 0, 8'h00);  // cycle 1: first cycle with rst low (IDLE)
    cmp_n++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      err_n++; $display("FAIL idle_cycle: req=%b valid=%b want 0 0", imem_req_valid, instr_valid);
    end
    for (int c = 2; c <= 40 && nh < 3; c++) begin
      cyc(0, 1, 1, 0, 8'h00);
      if (acc && na < 3) begin addrs[na] = acc_addr; na++; end
      if (instr_valid === 1'b1) begin
        if (first_v == 0) first_v = c;
        cmp_n++;
        if (instr !== ex_i[nh] || opcode !== ex_o[nh] || pc_out !== 8'(nh)) begin
          err_n++;
          $display("FAIL basic_instr%0d: instr=%h op=%h pc=%h want %h %h %h",
                   nh, instr, opcode, pc_out, ex_i[nh], ex_o[nh], nh);
        end
        if (nh > 0) begin
          cmp_n++;
          if (c - last_c != 3) begin
            err_n++; $display("FAIL basic_throughput: spacing=%0d want 3", c - last_c);
          end
        end
        last_c = c; nh++;
      end
    end
    cmp_n++;
    if (nh != 3 || na != 3) begin
      err_n++; $display("FAIL basic_timeout: instrs=%0d reqs=%0d want 3 3", nh, na);
    end else begin
      cmp_n++;
      if (addrs[0] !== 8'd0 || addrs[1] !== 8'd1 || addrs[2] !== 8'd2) begin
        err_n++; $display("FAIL basic_addrs: %h %h %h want 00 01 02", addrs[0], addrs[1], addrs[2]);
      end
    end
    cmp_n++;
    if (first_v != 4) begin
      err_n++; $display("FAIL basic_latency: first valid in cycle %0d want 4", first_v);
    end
  endtask

  task automatic test_stall();
    logic [15:0] hi; logic [7:0] hp; int b;
    b = 0;
    do begin cyc(0, 1, 0, 0, 8'h00); b++; end while (instr_valid !== 1'b1 && b < 20);
    hi = instr; hp = pc_out;
    cmp_n++;
    if (instr_valid !== 1'b1 || hp !== 8'd3 || hi !== mem[3]) begin
      err_n++; $display("FAIL stall_present: valid=%b pc=%h instr=%h want 1 03 %h", instr_valid, hp, hi, mem[3]);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      cmp_n++;
      if (instr !== hi || pc_out !== hp || instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
        err_n++;
        $display("FAIL stall_hold%0d: instr=%h pc=%h valid=%b req=%b want %h %h 1 0",
                 i, instr, pc_out, instr_valid, imem_req_valid, hi, hp);
      end
    end
    cyc(0, 1, 1, 0, 8'h00);
    b = 0;
    do begin cyc(0, 1, 1, 0, 8'h00); b++; end while (imem_req_valid !== 1'b1 && b < 20);
    cmp_n++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 8'(hp + 8'd1)) begin
      err_n++; $display("FAIL stall_next_addr: req=%b addr=%h want 1 %h", imem_req_valid, imem_addr, 8'(hp + 8'd1));
    end
  endtask

  task automatic test_branch_wait();
    int b; bit seen_ff, got_acc, got_hs;
    b = 0;
    do begin cyc(0, 0, 1, 0, 8'h00); b++; end while ((imem_req_valid !== 1'b1 || pend) && b < 20);
    mem_k = 3;
    cyc(0, 1, 1, 0, 8'h00);
    pdata = 16'hFFFF;  // the squashed response carries 0xFFFF
    cyc(0, 1, 1, 1, 8'h40);
    seen_ff = 0; got_acc = 0; got_hs = 0;
    for (int i = 0; i < 30 && !got_hs; i++) begin
      cyc(0, 1, 1, 0, 8'h00);
      if (instr_valid === 1'b1 && instr === 16'hFFFF) seen_ff = 1;
      if (acc && !got_acc) begin
        got_acc = 1;
        cmp_n++;
        if (acc_addr !== 8'h40) begin
          err_n++; $display("FAIL bw_target_addr: addr=%h want 40", acc_addr);
        end
      end
      if (instr_valid === 1'b1 && !got_hs) begin
        got_hs = 1;
        cmp_n++;
        if (pc_out !== 8'h40 || instr !== mem[8'h40]) begin
          err_n++; $display("FAIL bw_target_instr: pc=%h instr=%h want 40 %h", pc_out, instr, mem[8'h40]);
        end
      end
    end
    cmp_n++;
    if (seen_ff || !got_hs) begin
      err_n++; $display("FAIL bw_squash: ffff_presented=%0d target_presented=%0d want 0 1", seen_ff, got_hs);
    end
    repeat (3) cyc(0, 0, 0, 0, 8'h00);
`ifdef IF_PERF_CNT_EN
    cmp_n++;
    if (perf_flush_cnt !== 16'd1 || perf_fetch_cnt !== 16'(n_hs)) begin
      err_n++; $display("FAIL bw_perf: flush=%0d fetch=%0d want 1 %0d", perf_flush_cnt, perf_fetch_cnt, n_hs);
    end
`endif
    mem_k = 1;
  endtask

  task automatic test_branch_resp();
    mem_k = 1;
    cyc(0, 1, 1, 0, 8'h00);
    cmp_n++;
    if (!acc) begin
      err_n++; $display("FAIL br_accept: accepted=0 want 1");
    end
    cyc(0, 0, 1, 1, 8'h80);  // response and redirect in the same WAIT cycle
    cyc(0, 0, 0, 0, 8'h00);
    cmp_n++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 8'h80 || instr_valid !== 1'b0) begin
      err_n++; $display("FAIL br_fetch_target: req=%b addr=%h valid=%b want 1 80 0", imem_req_valid, imem_addr, instr_valid);
    end
  endtask

  task automatic test_wrap();
    int b;
    b = 0;
    do begin cyc(0, 1, 0, 0, 8'h00); b++; end while (instr_valid !== 1'b1 && b < 20);
    cyc(0, 1, 1, 1, 8'hFF);  // redirect in ISSUE drops the held instruction
    cyc(0, 0, 0, 0, 8'h00);
    cmp_n++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 8'hFF) begin
      err_n++; $display("FAIL wrap_redirect: valid=%b req=%b addr=%h want 0 1 ff", instr_valid, imem_req_valid, imem_addr);
    end
    b = 0;
    do begin cyc(0, 1, 1, 0, 8'h00); b++; end while (instr_valid !== 1'b1 && b < 20);
    cmp_n++;
    if (pc_out !== 8'hFF || instr !== mem[8'hFF]) begin
      err_n++; $display("FAIL wrap_ff: pc=%h instr=%h want ff %h", pc_out, instr, mem[8'hFF]);
    end
    b = 0;
    do begin cyc(0, 1, 1, 0, 8'h00); b++; end while (!acc && b < 20);
    cmp_n++;
    if (!acc || acc_addr !== 8'h00) begin
      err_n++; $display("FAIL wrap_addr: accepted=%0d addr=%h want 1 00", acc, acc_addr);
    end
    repeat (3) cyc(0, 0, 0, 0, 8'h00);
`ifdef IF_PERF_CNT_EN
    cmp_n++;
    if (perf_fetch_cnt !== 16'(n_hs) || perf_flush_cnt !== 16'(n_drop)) begin
      err_n++; $display("FAIL wrap_perf: fetch=%0d flush=%0d want %0d %0d", perf_fetch_cnt, perf_flush_cnt, n_hs, n_drop);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int b;
    b = 0;
    do begin cyc(0, 0, 1, 0, 8'h00); b++; end while ((imem_req_valid !== 1'b1 || pend) && b < 20);
    mem_k = 2;
    cyc(0, 1, 1, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);  // reset while waiting
    cyc(0, 0, 0, 0, 8'h00);  // stale response arrives now
    cmp_n++;
    if (imem_resp_valid !== 1'b1 || instr_valid !== 1'b0 || imem_req_valid !== 1'b0 ||
        instr !== 16'h0 || pc_out !== 8'h0 || opcode !== 4'h0) begin
      err_n++;
      $display("FAIL rst_mid_vals: stale=%b valid=%b req=%b instr=%h pc=%h op=%h want 1 0 0 0000 00 0",
               imem_resp_valid, instr_valid, imem_req_valid, instr, pc_out, opcode);
    end
`ifdef IF_PERF_CNT_EN
    cmp_n++;
    if (perf_fetch_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin
      err_n++; $display("FAIL rst_mid_perf: fetch=%0d flush=%0d want 0 0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
    mem_k = 1;
    cyc(0, 1, 1, 0, 8'h00);
    cmp_n++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 8'h00) begin
      err_n++; $display("FAIL rst_mid_restart: valid=%b req=%b addr=%h want 0 1 00", instr_valid, imem_req_valid, imem_addr);
    end
    b = 0;
    do begin cyc(0, 1, 1, 0, 8'h00); b++; end while (instr_valid !== 1'b1 && b < 20);
    cmp_n++;
    if (pc_out !== 8'h00 || instr !== mem[0]) begin
      err_n++; $display("FAIL rst_mid_first: pc=%h instr=%h want 00 %h", pc_out, instr, mem[0]);
    end
  endtask

  // Reference: presented instructions walk sequential addresses from RESET_PC,
  // restarting at the target after every redirect; data is the memory image.
  task automatic test_random();
    logic [7:0] exp_pc, tgt; bit rdy, irdy, br, prev_br; int nchk;
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    pend = 0; overlap = 0;
    exp_pc = 8'h00; prev_br = 0; nchk = 0;
    for (int i = 0; i < 1500; i++) begin
      rdy  = ($urandom_range(0, 9) < 7);
      irdy = ($urandom_range(0, 9) < 6);
      br   = ($urandom_range(0, 29) == 0);
      tgt  = 8'($urandom);
      mem_k = $urandom_range(1, 3);
      cyc(0, rdy, irdy, br, tgt);
      if (prev_br) begin
        cmp_n++;
        if (instr_valid !== 1'b0) begin
          err_n++; $display("FAIL rnd_redirect_valid: cycle=%0d valid=%b want 0", i, instr_valid);
        end
      end
      if (instr_valid === 1'b1 && irdy && !br) begin
        cmp_n++; nchk++;
        if (pc_out !== exp_pc || instr !== mem[exp_pc] || opcode !== mem[exp_pc][15:12]) begin
          err_n++;
          $display("FAIL rnd_instr: cycle=%0d pc=%h instr=%h op=%h want %h %h %h",
                   i, pc_out, instr, opcode, exp_pc, mem[exp_pc], mem[exp_pc][15:12]);
        end
        exp_pc = exp_pc + 8'd1;
      end
      if (br) exp_pc = tgt;
      prev_br = br;
    end
    repeat (5) cyc(0, 0, 0, 0, 8'h00);
    cmp_n++;
    if (overlap != 0 || nchk < 50) begin
      err_n++; $display("FAIL rnd_protocol: overlaps=%0d delivered=%0d want 0 >=50", overlap, nchk);
    end
`ifdef IF_PERF_CNT_EN
    cmp_n++;
    if (perf_fetch_cnt !== 16'(n_hs) || perf_flush_cnt !== 16'(n_drop)) begin
      err_n++; $display("FAIL rnd_perf: fetch=%0d flush=%0d want %0d %0d", perf_fetch_cnt, perf_flush_cnt, n_hs, n_drop);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1000; mem[1] = 16'h2345; mem[2] = 16'h3ABC;
    test_reset();
    test_basic();
    test_stall();
    test_branch_wait();
    test_branch_resp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  // Absolute time limit so the bench always ends on its own.
  initial begin
    #500000;
    $display("FAIL timeout: sim time limit reached, compared=%0d", cmp_n);
    $fatal(1, "time limit");
  end
endmodule
